linear_layer_start_fifo_srl_ctrl: RTL and testbench

Control-side wrapper that turns the per-PE shift-register storage into a complete start-token FIFO between two Linear_Layer dataflow processes (e.g. the producer that launches `PE_i4xi4_pack_2x2`).
- It owns the write handshake, the occupancy counter, the read-address generation and the read handshake.
- The shift-register array is instantiated inside this block.
- The consumer sees a first-word-fall-through interface: head token on `if_dout`, qualified by `if_empty_n`.

---
 rtl/linear_layer_start_fifo_srl_ctrl.sv | 115 +++++++++++
 tb/tb_linear_layer_start_fifo_srl_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/linear_layer_start_fifo_srl_ctrl.sv
// Start-token FIFO built on a shift-register array, with a first-word-fall-through read side.
// Optional macro START_FIFO_OUT_REG_EN adds a registered output stage, giving DEPTH+1 total capacity.
module linear_layer_start_fifo_srl_ctrl #(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 1,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  if_write_ce,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_full_n,
    input  logic                  if_read_ce,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic                  if_empty_n
);

    localparam int                CNT_W    = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_cnt_next;
    logic                  r_full_n;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_take;
    logic [ADDR_WIDTH-1:0] w_raddr;
    logic [DATA_WIDTH-1:0] w_head;

    assign w_push  = if_write & if_write_ce & r_full_n;
    assign w_pop   = if_read & if_read_ce & if_empty_n;
    // Newest token lives at entry 0, so the oldest sits at cnt-1.
    assign w_raddr = r_cnt[ADDR_WIDTH-1:0] - ADDR_WIDTH'(1);

    always_ff @(posedge clk) begin
        if (reset_n && w_push) begin
            r_mem[0] <= if_din;
            for (int i = 1; i < DEPTH; i++) begin
                r_mem[i] <= r_mem[i-1];
            end
        end
    end

    always_comb begin
        w_head = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_raddr == i[ADDR_WIDTH-1:0]) begin
                w_head = r_mem[i];
            end
        end
    end

`ifdef START_FIFO_OUT_REG_EN
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_data;

    // Refill the output stage whenever it is empty or being drained this cycle.
    assign w_take = (~r_out_valid | w_pop) & (r_cnt != '0);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (w_take) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_head;
        end else if (w_pop) begin
            r_out_valid <= 1'b0;
        end
    end

    assign if_empty_n = r_out_valid;
    assign if_dout    = r_out_data;
`else
    logic r_empty_n;

    assign w_take = w_pop;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_empty_n <= 1'b0;
        end else begin
            r_empty_n <= (w_cnt_next != '0);
        end
    end

    assign if_empty_n = r_empty_n;
    assign if_dout    = w_head;
`endif

    always_comb begin
        w_cnt_next = r_cnt;
        if (w_push && !w_take) begin
            w_cnt_next = r_cnt + CNT_W'(1);
        end else if (!w_push && w_take) begin
            w_cnt_next = r_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cnt    <= '0;
            r_full_n <= 1'b1;
        end else begin
            r_cnt    <= w_cnt_next;
            r_full_n <= (w_cnt_next != CNT_FULL);
        end
    end

    assign if_full_n = r_full_n;

endmodule

// File: tb/tb_linear_layer_start_fifo_srl_ctrl.sv
// Randomized and directed bench for linear_layer_start_fifo_srl_ctrl against a token-queue reference model.
// Honours START_FIFO_OUT_REG_EN when the design is built with it.
module tb_linear_layer_start_fifo_srl_ctrl;

    localparam int DW    = 8;
    localparam int AW    = 1;
    localparam int DEPTH = 2;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          if_write_ce = 1'b0;
    logic          if_write = 1'b0;
    logic [DW-1:0] if_din = '0;
    logic          if_read_ce = 1'b0;
    logic          if_read = 1'b0;
    logic          if_full_n;
    logic [DW-1:0] if_dout;
    logic          if_empty_n;

    linear_layer_start_fifo_srl_ctrl #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .DEPTH     (DEPTH)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .if_write_ce(if_write_ce),
        .if_write   (if_write),
        .if_din     (if_din),
        .if_full_n  (if_full_n),
        .if_read_ce (if_read_ce),
        .if_read    (if_read),
        .if_dout    (if_dout),
        .if_empty_n (if_empty_n)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: every token held by the FIFO, oldest first, with the edge it arrived on.
    logic [DW-1:0] mq[$];
    int            mt[$];
    bit            shown = 1'b0;

    logic [DW-1:0] sent[$];
    int            ridx = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic bit m_full_n();
`ifdef START_FIFO_OUT_REG_EN
        return (mq.size() - int'(shown)) != DEPTH;
`else
        return mq.size() != DEPTH;
`endif
    endfunction

    // One clock: drive at negedge, update the model on the edge, compare at the next negedge.
    task automatic step(input bit rst_n, input bit wr, input bit wce, input logic [DW-1:0] din,
                        input bit rd, input bit rce);
        bit push;
        bit pop;
        reset_n     = rst_n;
        if_write    = wr;
        if_write_ce = wce;
        if_din      = din;
        if_read     = rd;
        if_read_ce  = rce;
        push = wr && wce && m_full_n();
        pop  = rd && rce && shown;
        @(posedge clk);
        cyc++;
        if (!rst_n) begin
            mq.delete();
            mt.delete();
            shown = 1'b0;
        end else begin
            if (pop) begin
                void'(mq.pop_front());
                void'(mt.pop_front());
                shown = 1'b0;
            end
`ifdef START_FIFO_OUT_REG_EN
            // A token reaches the output stage one edge after it was stored.
            if (!shown && mq.size() > 0 && mt[0] < cyc) shown = 1'b1;
            if (push) begin
                mq.push_back(din);
                mt.push_back(cyc);
            end
`else
            if (push) begin
                mq.push_back(din);
                mt.push_back(cyc);
            end
            shown = (mq.size() > 0);
`endif
        end
        @(negedge clk);
        $display("cyc %0d rst_n=%0b push=%0b pop=%0b din=%02h | empty_n=%0b full_n=%0b dout=%02h",
                 cyc, rst_n, push && rst_n, pop && rst_n, din, if_empty_n, if_full_n, if_dout);
        check("empty_n", {31'd0, if_empty_n}, {31'd0, shown});
        check("full_n", {31'd0, if_full_n}, {31'd0, m_full_n()});
        if (shown) check("dout", {24'd0, if_dout}, {24'd0, mq[0]});
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && mq.size() > 0; i++) begin
            if (shown) step(1, 0, 0, 8'h00, 1, 1);
            else       step(1, 0, 0, 8'h00, 0, 0);
        end
        check("drained", mq.size(), 0);
    endtask

    initial begin
        logic [DW-1:0] exp_list[$];
        @(negedge clk);

        // Reset then idle
        step(0, 0, 0, 8'h00, 0, 0);
        check("rst_empty_n", {31'd0, if_empty_n}, 32'd0);
        check("rst_full_n", {31'd0, if_full_n}, 32'd1);
`ifdef START_FIFO_OUT_REG_EN
        check("rst_dout", {24'd0, if_dout}, 32'd0);
`endif
        step(1, 0, 0, 8'h00, 0, 0);

        // Fill / drain
        step(1, 1, 1, 8'hA1, 0, 0);
        step(1, 1, 1, 8'hB2, 0, 0);
`ifndef START_FIFO_OUT_REG_EN
        check("full_after_two", {31'd0, if_full_n}, 32'd0);
        exp_list = '{8'hA1, 8'hB2};
`else
        exp_list = '{8'hA1, 8'hB2, 8'hC3};
`endif
        step(1, 1, 1, 8'hC3, 0, 0);
`ifdef START_FIFO_OUT_REG_EN
        check("full_after_three", {31'd0, if_full_n}, 32'd0);
`endif
        foreach (exp_list[i]) begin
            check("drain_head", {24'd0, if_dout}, {24'd0, exp_list[i]});
            step(1, 0, 0, 8'h00, 1, 1);
        end
        check("drain_empty", {31'd0, if_empty_n}, 32'd0);

        // Simultaneous push/pop at one token
        step(1, 1, 1, 8'h11, 0, 0);
        step(1, 0, 0, 8'h00, 0, 0);
        check("pp_head", {24'd0, if_dout}, 32'h11);
        step(1, 1, 1, 8'h22, 1, 1);
`ifndef START_FIFO_OUT_REG_EN
        check("pp_dout", {24'd0, if_dout}, 32'h22);
        check("pp_empty_n", {31'd0, if_empty_n}, 32'd1);
        check("pp_full_n", {31'd0, if_full_n}, 32'd1);
`endif
        drain();

        // Clock-enable gating
        repeat (3) step(1, 1, 0, 8'h77, 0, 0);
        check("wce_gate", {31'd0, if_empty_n}, 32'd0);
        step(1, 1, 1, 8'h33, 0, 0);
        step(1, 0, 0, 8'h00, 0, 0);
        repeat (3) step(1, 0, 0, 8'h00, 1, 0);
        check("rce_gate", {31'd0, if_empty_n}, 32'd1);
        check("rce_head", {24'd0, if_dout}, 32'h33);
        drain();

        // Reset mid-operation
        step(1, 1, 1, 8'h01, 0, 0);
        step(1, 1, 1, 8'h02, 0, 0);
        step(0, 1, 1, 8'h55, 0, 0);
        check("midrst_empty_n", {31'd0, if_empty_n}, 32'd0);
        check("midrst_full_n", {31'd0, if_full_n}, 32'd1);
        step(1, 1, 1, 8'h66, 0, 0);
        step(1, 0, 0, 8'h00, 0, 0);
        check("midrst_head", {24'd0, if_dout}, 32'h66);
        drain();

        // Random streaming under read stalls
        for (int c = 0; c < 3000 && ridx < 100; c++) begin
            bit            wr;
            bit            wce;
            bit            rd;
            bit            rce;
            logic [DW-1:0] d;
            wr  = (sent.size() < 100) && ($urandom_range(0, 3) != 0);
            wce = ($urandom_range(0, 7) != 0);
            rd  = ($urandom_range(0, 2) != 0);
            rce = ($urandom_range(0, 7) != 0);
            d   = DW'($urandom);
            if (wr && wce && m_full_n()) sent.push_back(d);
            if (rd && rce && shown) begin
                check("stream_data", {24'd0, if_dout}, {24'd0, sent[ridx]});
                ridx++;
            end
            step(1, wr, wce, d, rd, rce);
        end
        check("stream_count", ridx, 100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
